burst_grant_holder: RTL and testbench

- Sits directly downstream of the combinational Fixed_Priority_Arbiter and turns its single-cycle one-hot grant into a registered burst ownership lock.
- Drives the arbiter's request inputs and latches the resulting grant.
- Holds the winning port as owner until its burst ends, muxing that port's valid/data/last stream onto one shared output channel with valid/ready flow control.

---
 rtl/burst_grant_holder.sv | 155 +++++++++++++++
 tb/tb_burst_grant_holder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_grant_holder.sv
// -----------------------------------------------------------------------------
// burst_grant_holder
//
// Purpose:
//   Sits behind a combinational fixed-priority arbiter. Forwards requests to
//   the arbiter while idle, latches the resulting one-hot grant as the burst
//   owner, and then muxes the owner's valid/data/last stream onto one shared
//   output channel until the burst ends (last beat, beat limit, or abandon).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   req_i        per-port ownership request
//   valid_i      per-port beat valid
//   last_i       per-port last-beat flag (qualified by valid_i)
//   data_i       flattened per-port data, port p at [p*DATA_W +: DATA_W]
//   ready_o      per-port ready, only the owner's bit may be set
//   arb_req_o    request vector to the arbiter
//   arb_gnt_i    one-hot (or zero) grant from the arbiter
//   gnt_o        current owner, one-hot, zero when idle
//   out_valid_o  shared channel valid
//   out_data_o   shared channel data
//   out_last_o   shared channel last (also set on a forced final beat)
//   out_ready_i  shared channel ready
//   truncated_o  one-cycle pulse after a burst is cut at MAX_BEATS
// -----------------------------------------------------------------------------
module burst_grant_holder #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          req_i,
    input  logic [NUM_PORTS-1:0]          valid_i,
    input  logic [NUM_PORTS-1:0]          last_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_i,
    output logic [NUM_PORTS-1:0]          ready_o,
    output logic [NUM_PORTS-1:0]          arb_req_o,
    input  logic [NUM_PORTS-1:0]          arb_gnt_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    output logic                          out_valid_o,
    output logic [DATA_W-1:0]             out_data_o,
    output logic                          out_last_o,
    input  logic                          out_ready_i,
    output logic                          truncated_o
);

    localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                 state_q;
    logic [NUM_PORTS-1:0]   owner_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [CNT_W-1:0]       beat_cnt_d;
    logic                   truncated_q;

    logic                   locked;
    logic                   owner_valid;
    logic                   owner_last;
    logic                   owner_req;
    logic                   at_max;
    logic                   xfer;
    logic [DATA_W-1:0]      owner_data;

    assign locked      = (state_q == LOCKED);
    assign owner_valid = |(valid_i & owner_q);
    assign owner_last  = |(last_i  & owner_q);
    assign owner_req   = |(req_i   & owner_q);
    assign at_max      = (beat_cnt_q == LAST_CNT);
    assign beat_cnt_d  = beat_cnt_q + CNT_W'(1);

    // Owner data select; owner_q is one-hot or zero, so OR-ing masked slices
    // yields the owner's beat, or zero while idle.
    always_comb begin
        owner_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (owner_q[p]) begin
                owner_data = owner_data | data_i[p*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake is suppressed while reset is asserted so no beat completes
    // on a reset edge.
    assign out_valid_o = locked & owner_valid & ~rst_i;
    assign ready_o     = (locked && !rst_i && out_ready_i) ? owner_q : '0;
    assign out_last_o  = out_valid_o & (owner_last | at_max);
    assign out_data_o  = owner_data;
    assign xfer        = out_valid_o & out_ready_i;

    // Requests reach the arbiter only while idle; masking them while locked
    // keeps the arbiter from producing a competing grant.
    assign arb_req_o   = (!locked && !rst_i) ? req_i : '0;
    assign gnt_o       = locked ? owner_q : '0;
    assign truncated_o = truncated_q;

    // Ownership state machine.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            beat_cnt_q  <= '0;
            truncated_q <= 1'b0;
        end else begin
            truncated_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|arb_gnt_i) begin
                        owner_q    <= arb_gnt_i;
                        beat_cnt_q <= '0;
                        state_q    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (owner_last || at_max) begin
                            // Burst ends; flag it only when the limit, not
                            // the requester, closed it.
                            state_q     <= IDLE;
                            owner_q     <= '0;
                            beat_cnt_q  <= '0;
                            truncated_q <= at_max & ~owner_last;
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end else if (!owner_req && !owner_valid) begin
                        // Owner walked away without finishing its burst.
                        state_q    <= IDLE;
                        owner_q    <= '0;
                        beat_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    owner_q <= '0;
                end
            endcase
        end
    end

    // A multi-hot grant from the arbiter would corrupt ownership.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !locked) begin
            assert ($countones(arb_gnt_i) <= 1)
                else $error("burst_grant_holder: multi-hot arb_gnt_i %b", arb_gnt_i);
        end
    end

endmodule

// File: tb/tb_burst_grant_holder.sv
// -----------------------------------------------------------------------------
// tb_burst_grant_holder
//
// Drives burst_grant_holder with a behavioural fixed-priority arbiter model on
// its arbiter interface, runs directed burst scenarios followed by randomized
// traffic, and compares all outputs every cycle against a reference model
// that tracks the owner as a port number and counts transferred beats.
// -----------------------------------------------------------------------------
module tb_burst_grant_holder;

    localparam int unsigned NUM_PORTS = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BEATS = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ready;
    logic [3:0]  arb_req;
    logic [3:0]  arb_gnt;
    logic [3:0]  gnt;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        trunc;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner port (-1 when idle), beats sent, pulse.
    int m_owner = -1;
    int m_cnt   = 0;
    bit m_trunc = 1'b0;
    bit model_on = 1'b0;

    burst_grant_holder #(
        .NUM_PORTS (NUM_PORTS),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .valid_i     (valid),
        .last_i      (last),
        .data_i      (data),
        .ready_o     (ready),
        .arb_req_o   (arb_req),
        .arb_gnt_i   (arb_gnt),
        .gnt_o       (gnt),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_ready_i (out_ready),
        .truncated_o (trunc)
    );

    // Fixed-priority arbiter: lowest requesting index wins.
    assign arb_gnt = arb_req & (~arb_req + 4'd1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_trunc = 1'b0;
    endtask

    // Expected outputs from model state plus current inputs.
    task automatic model_check();
        logic [3:0] e_gnt;
        logic [3:0] e_arb;
        logic [3:0] e_ready;
        logic       e_valid;
        logic       e_last;
        logic [7:0] e_data;
        e_gnt = 4'b0; e_arb = 4'b0; e_ready = 4'b0;
        e_valid = 1'b0; e_last = 1'b0; e_data = 8'h0;
        if (m_owner >= 0) begin
            e_gnt  = 4'b0001 << m_owner;
            e_data = data[m_owner*8 +: 8];
            if (!rst) begin
                e_valid = valid[m_owner];
                e_ready = out_ready ? e_gnt : 4'b0;
                e_last  = e_valid && (last[m_owner] || m_cnt == MAX_BEATS - 1);
            end
        end else if (!rst) begin
            e_arb = req;
        end
        check("gnt",       32'(gnt),       32'(e_gnt));
        check("arb_req",   32'(arb_req),   32'(e_arb));
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("ready",     32'(ready),     32'(e_ready));
        check("out_data",  32'(out_data),  32'(e_data));
        check("out_last",  32'(out_last),  32'(e_last));
        check("truncated", 32'(trunc),     32'(m_trunc));
    endtask

    // Advance the model by one clock edge using the inputs held this cycle.
    task automatic model_update();
        int pick;
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            m_trunc = 1'b0;
            pick = -1;
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (req[p]) pick = p;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_cnt   = 0;
            end
        end else begin
            m_trunc = 1'b0;
            if (valid[m_owner] && out_ready) begin
                m_cnt++;
                if (last[m_owner] || m_cnt == MAX_BEATS) begin
                    m_trunc = !last[m_owner] && (m_cnt == MAX_BEATS);
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end else if (!req[m_owner] && !valid[m_owner]) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    endtask

    // One clock: check at the falling edge, update model at the rising edge.
    task automatic tick();
        @(negedge clk);
        if (model_on) model_check();
        @(posedge clk);
        if (model_on) model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 4'b1111; valid = 4'b0; last = 4'b0;
        data = 32'h0; out_ready = 1'b0;

        // Reset held for two cycles with all ports requesting.
        @(posedge clk); #1;
        model_reset();
        model_on = 1'b1;
        tick();
        check("rst_gnt",     32'(gnt),       32'h0);
        check("rst_valid",   32'(out_valid), 32'h0);
        check("rst_ready",   32'(ready),     32'h0);
        check("rst_arb_req", 32'(arb_req),   32'h0);
        rst = 1'b0;
        #1;
        check("post_rst_arb_req", 32'(arb_req), 32'hF);
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // Backpressure: port 0 owns, channel stalled for three cycles.
        req = 4'b0001; valid = 4'b0001; data = 32'h11; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_data",  32'(out_data),  32'h11);
            check("bp_ready", 32'(ready),     32'h0);
            check("bp_valid", 32'(out_valid), 32'h1);
            tick();
        end
        out_ready = 1'b1; last = 4'b0001; req = 4'b0000;
        #1;
        check("bp_release_ready", 32'(ready), 32'h1);
        tick();
        check("bp_done_gnt", 32'(gnt), 32'h0);

        // Contention: ports 1 and 3 request, port 1 wins and sends 3 beats.
        valid = 4'b0; last = 4'b0; req = 4'b1010; data = 32'h0;
        tick();
        check("cont_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 3; i++) begin
            valid = 4'b0010;
            data  = 32'(8'hA1 + 8'(i)) << 8;
            last  = (i == 2) ? 4'b0010 : 4'b0000;
            req   = (i == 2) ? 4'b1000 : 4'b1010;
            #1;
            check("cont_data", 32'(out_data), 32'(8'hA1 + 8'(i)));
            tick();
        end
        valid = 4'b0; last = 4'b0;
        #1;
        check("cont_idle_gnt", 32'(gnt), 32'h0);
        tick();
        check("cont_next_gnt", 32'(gnt), 32'h8);

        // Abandon: owner port 3 drops its request without valid.
        req = 4'b0000;
        tick();
        check("abandon_gnt", 32'(gnt), 32'h0);

        // Truncation: port 2 sends four beats without last.
        req = 4'b0100;
        tick();
        check("trunc_gnt", 32'(gnt), 32'h4);
        for (int i = 0; i < 4; i++) begin
            valid = 4'b0100;
            data  = 32'(8'h20 + 8'(i)) << 16;
            req   = (i == 3) ? 4'b0000 : 4'b0100;
            #1;
            check("trunc_last", 32'(out_last), (i == 3) ? 32'h1 : 32'h0);
            tick();
        end
        valid = 4'b0;
        #1;
        check("trunc_pulse", 32'(trunc), 32'h1);
        check("trunc_gnt0",  32'(gnt),   32'h0);
        tick();
        check("trunc_pulse_end", 32'(trunc), 32'h0);

        // Reset in the middle of a burst, then a normal regrant.
        req = 4'b0100;
        tick();
        for (int i = 0; i < 2; i++) begin
            valid = 4'b0100;
            data  = 32'(8'h30 + 8'(i)) << 16;
            tick();
        end
        rst = 1'b1;
        tick();
        check("midrst_gnt",   32'(gnt),       32'h0);
        check("midrst_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; valid = 4'b0; req = 4'b0100;
        tick();
        check("midrst_regrant", 32'(gnt), 32'h4);
        valid = 4'b0100; last = 4'b0100; req = 4'b0000;
        tick();
        valid = 4'b0; last = 4'b0;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            data      = $urandom;
            for (int p = 0; p < NUM_PORTS; p++) begin
                valid[p] = ($urandom_range(0, 3) != 0);
                last[p]  = ($urandom_range(0, 4) == 0);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
